serial_add_ctrl: RTL and testbench

Sequencer that computes an N-bit sum with one instance of the team's 1-bit `FullAdder` cell (ports `A`, `B`, `C`, `Sum`, `Cy`). It processes the operands one bit per clock, LSB first, and keeps the running carry in a flip-flop. The block sits between a requester that issues Start/operands and the shared single-bit adder cell. It trades N cycles of latency for minimal adder area.

---
 rtl/serial_add_ctrl.sv | 151 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder sequencer. Computes {Cy, Sum} = A + B + Cin using a single
//   1-bit full-adder cell, one bit per clock, LSB first, with the running carry
//   held in a flop. An operation takes N RUN cycles followed by one DONE cycle.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst    : asynchronous active-high reset
//   Start  : request, accepted only in IDLE or DONE
//   A, B   : N-bit operands, captured on the accepting edge
//   Cin    : carry-in, captured on the accepting edge
//   Busy   : high while bits are being processed (state RUN)
//   Done   : one-cycle pulse in the cycle after Sum/Cy update (state DONE)
//   Sum    : result register, holds the last completed result
//   Cy     : carry-out of the last completed result
module serial_add_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Sum,
  output logic         Cy
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Shared 1-bit full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic c);
    full_adder = {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  state_t        state_q, state_d;
  logic [N-1:0]  sa_q, sa_d;
  logic [N-1:0]  sb_q, sb_d;
  logic [N-1:0]  sr_q, sr_d;
  logic          c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cy_q, cy_d;

  logic [1:0]    fa_res;
  logic          fa_sum;
  logic          fa_cy;

  // The adder cell always sees the current LSBs and the running carry.
  assign fa_res = full_adder(sa_q[0], sb_q[0], c_q);
  assign fa_sum = fa_res[0];
  assign fa_cy  = fa_res[1];

  assign Busy = busy_q;
  assign Done = done_q;
  assign Sum  = sum_q;
  assign Cy   = cy_q;

  // Next-state and datapath logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new request exactly like IDLE (back-to-back).
        if (Start) begin
          sa_d    = A;
          sb_d    = B;
          c_d     = Cin;
          cnt_d   = {CW{1'b0}};
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        sa_d = {1'b0, sa_q[N-1:1]};
        sb_d = {1'b0, sb_q[N-1:1]};
        sr_d = {fa_sum, sr_q[N-1:1]};
        c_d  = fa_cy;
        if (cnt_q == CNT_LAST) begin
          // Final bit: publish the full result on this same edge. The counter
          // is left alone so it never wraps when N is a power of two.
          sum_d   = {fa_sum, sr_q[N-1:1]};
          cy_d    = fa_cy;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= {N{1'b0}};
      sb_q    <= {N{1'b0}};
      sr_q    <= {N{1'b0}};
      c_q     <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= {N{1'b0}};
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl (N=8). Expected results come from
//   plain (N+1)-bit addition of the operands; timing expectations come from the
//   N-cycle Busy / one-cycle Done protocol. Inputs change and outputs are
//   sampled on the falling clock edge.
module tb_serial_add_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         Start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         Busy;
  logic         Done;
  logic [N-1:0] Sum;
  logic         Cy;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cy    (Cy)
  );

  always #5 clk = ~clk;

  // Reference: {Cy, Sum} is simply the (N+1)-bit sum of the inputs.
  function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
    ref_add = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
  endfunction

  // Issue one request (called right after a falling edge) and observe N+4
  // samples: busy cycles, Done pulses, first-Done sample index and result.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                       output int bc, output int dc, output int lat,
                       output logic [N-1:0] s, output logic c);
    bc = 0; dc = 0; lat = -1; s = {N{1'b0}}; c = 1'b0;
    Start = 1'b1; A = a; B = b; Cin = ci;
    @(negedge clk);
    Start = 1'b0; A = N'($urandom); B = N'($urandom); Cin = 1'($urandom_range(0, 1));
    for (int i = 0; i < N + 4; i++) begin
      if (Busy) bc++;
      if (Done) begin
        if (dc == 0) begin s = Sum; c = Cy; lat = i; end
        dc++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; Start = 1'b0; A = {N{1'b0}}; B = {N{1'b0}}; Cin = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
    checks++; if (Sum !== {N{1'b0}}) begin errors++; $display("FAIL reset_sum: got %h expected 00", Sum); end
    checks++; if (Cy !== 1'b0) begin errors++; $display("FAIL reset_cy: got %b expected 0", Cy); end
    rst = 1'b0;
    // Start raised mid-cycle must not reach Busy/Done before a clock edge.
    Start = 1'b1; A = 8'hFF; B = 8'hFF; Cin = 1'b1;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL comb_path_busy: got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL comb_path_done: got %b expected 0", Done); end
    Start = 1'b0;
    @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", Busy); end
  endtask

  task automatic test_basic;
    logic [N-1:0] va [2] = '{8'h5A, 8'hFF};
    logic [N-1:0] vb [2] = '{8'h33, 8'h01};
    logic [N:0]   exp_v [2] = '{9'h08D, 9'h100};
    int bc, dc, lat;
    logic [N-1:0] s;
    logic c;
    for (int k = 0; k < 2; k++) begin
      do_op(va[k], vb[k], 1'b0, bc, dc, lat, s, c);
      checks++; if (bc != N) begin errors++; $display("FAIL basic%0d_busy_cycles: got %0d expected %0d", k, bc, N); end
      checks++; if (dc != 1) begin errors++; $display("FAIL basic%0d_done_pulses: got %0d expected 1", k, dc); end
      checks++; if (lat != N) begin errors++; $display("FAIL basic%0d_latency: got %0d expected %0d", k, lat, N); end
      checks++; if ({c, s} !== exp_v[k]) begin errors++; $display("FAIL basic%0d_result: got %h expected %h", k, {c, s}, exp_v[k]); end
    end
  endtask

  task automatic test_max_hold;
    int bc, dc, lat;
    logic [N-1:0] s;
    logic c;
    do_op(8'hFF, 8'hFF, 1'b1, bc, dc, lat, s, c);
    checks++; if ({c, s} !== ref_add(8'hFF, 8'hFF, 1'b1)) begin errors++; $display("FAIL max_result: got %h expected 1ff", {c, s}); end
    checks++; if (dc != 1) begin errors++; $display("FAIL max_done_pulses: got %0d expected 1", dc); end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({Done, Cy, Sum} !== {1'b0, 1'b1, 8'hFF}) begin errors++; $display("FAIL max_hold%0d: got done=%b cy=%b sum=%h expected 0 1 ff", i, Done, Cy, Sum); end
      @(negedge clk);
    end
  endtask

  task automatic test_start_during_run;
    int bc = 0;
    int dc = 0;
    logic [N-1:0] s = {N{1'b0}};
    logic c = 1'b0;
    Start = 1'b1; A = 8'h10; B = 8'h20; Cin = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    for (int i = 0; i < N + 6; i++) begin
      if (Busy) bc++;
      if (Done) begin
        if (dc == 0) begin s = Sum; c = Cy; end
        dc++;
      end
      Start = (i == 3);
      if (i == 3) begin A = 8'hAA; B = 8'h55; Cin = 1'b1; end
      @(negedge clk);
    end
    checks++; if (bc != N) begin errors++; $display("FAIL sdr_busy_cycles: got %0d expected %0d", bc, N); end
    checks++; if (dc != 1) begin errors++; $display("FAIL sdr_done_pulses: got %0d expected 1", dc); end
    checks++; if ({c, s} !== ref_add(8'h10, 8'h20, 1'b0)) begin errors++; $display("FAIL sdr_result: got %h expected 030", {c, s}); end
  endtask

  task automatic test_back_to_back;
    int dc = 0;
    int d1 = -1;
    int d2 = -1;
    int ovl = 0;
    Start = 1'b1; A = 8'h01; B = 8'h02; Cin = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2 * N + 8; i++) begin
      if (Busy && Done) ovl++;
      if (d1 >= 0 && i == d1 + 1) begin
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept_busy: got %b expected 1", Busy); end
        Start = 1'b0;
      end
      if (Done) begin
        dc++;
        if (dc == 1) begin
          d1 = i;
          checks++; if ({Cy, Sum} !== ref_add(8'h01, 8'h02, 1'b0)) begin errors++; $display("FAIL b2b_first_result: got %h expected 003", {Cy, Sum}); end
          checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_drop: got %b expected 0", Busy); end
          A = 8'h80; B = 8'h80; Cin = 1'b0;
        end else if (dc == 2) begin
          d2 = i;
          checks++; if ({Cy, Sum} !== ref_add(8'h80, 8'h80, 1'b0)) begin errors++; $display("FAIL b2b_second_result: got %h expected 100", {Cy, Sum}); end
        end
      end
      @(negedge clk);
    end
    Start = 1'b0;
    checks++; if (dc != 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 2", dc); end
    checks++; if (d1 != N) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", d1, N); end
    checks++; if (d2 != 2 * N + 1) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", d2, 2 * N + 1); end
    checks++; if (ovl != 0) begin errors++; $display("FAIL b2b_overlap: got %0d expected 0", ovl); end
  endtask

  task automatic test_random;
    int bc, dc, lat;
    logic [N-1:0] s, a, b;
    logic c, ci;
    logic [N:0] exp_v;
    for (int k = 0; k < 40; k++) begin
      a = N'($urandom); b = N'($urandom); ci = 1'($urandom_range(0, 1));
      exp_v = ref_add(a, b, ci);
      do_op(a, b, ci, bc, dc, lat, s, c);
      checks++; if ({c, s} !== exp_v) begin errors++; $display("FAIL rand%0d_result: %h+%h+%b got %h expected %h", k, a, b, ci, {c, s}, exp_v); end
      checks++; if (bc != N || dc != 1 || lat != N) begin errors++; $display("FAIL rand%0d_timing: got busy=%0d done=%0d lat=%0d expected %0d 1 %0d", k, bc, dc, lat, N, N); end
    end
  endtask

  task automatic test_reset_mid_run;
    int bc, dc, lat;
    int stray = 0;
    logic [N-1:0] s;
    logic c;
    // Leave a known non-zero result in the output registers first.
    do_op(8'h12, 8'h34, 1'b1, bc, dc, lat, s, c);
    checks++; if ({c, s} !== ref_add(8'h12, 8'h34, 1'b1)) begin errors++; $display("FAIL rmr_pre_result: got %h expected 047", {c, s}); end
    Start = 1'b1; A = 8'h0F; B = 8'h01; Cin = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rmr_running: got %b expected 1", Busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({Busy, Done, Cy, Sum} !== {N + 3{1'b0}}) begin errors++; $display("FAIL rmr_async_clear: got busy=%b done=%b cy=%b sum=%h expected all 0", Busy, Done, Cy, Sum); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      if (Done || Busy) stray++;
      @(negedge clk);
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rmr_no_done: got %0d active cycles expected 0", stray); end
    do_op(8'h0F, 8'h01, 1'b0, bc, dc, lat, s, c);
    checks++; if ({c, s} !== ref_add(8'h0F, 8'h01, 1'b0)) begin errors++; $display("FAIL rmr_fresh_result: got %h expected 010", {c, s}); end
    checks++; if (bc != N || dc != 1) begin errors++; $display("FAIL rmr_fresh_timing: got busy=%0d done=%0d expected %0d 1", bc, dc, N); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max_hold;
    test_start_during_run;
    test_back_to_back;
    test_random;
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
